// File: rtl/joystick_cursor_nav_pkg.sv
// Shared LCD constants, cursor/command types and the DDRAM command helper.
// The LCD_* values are common with the I2C LCD driver (same values as lcd_defs.vh).
package joystick_cursor_nav_pkg;

  localparam logic [7:0]  LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0]  LCD_ROW1_BASE     = 8'h40;
  localparam int unsigned LCD_COLS          = 16;
  localparam int unsigned LCD_ROWS          = 2;

  localparam int unsigned CMD_W = 8;
  localparam int unsigned COL_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } cmd_state_e;

  typedef struct packed {
    logic             row;
    logic [COL_W-1:0] col;
  } cursor_pos_t;

  // Build the "set DDRAM address" command byte for a cursor position.
  function automatic logic [CMD_W-1:0] ddram_cmd(input cursor_pos_t pos,
                                                 input logic [CMD_W-1:0] row1_base);
    logic [CMD_W-1:0] addr;
    addr = (pos.row ? row1_base : 8'h00) + {4'h0, pos.col};
    return LCD_CMD_SET_DDRAM | addr;
  endfunction

endpackage

// File: rtl/joystick_cursor_nav_if.sv
// Valid/ready command channel toward the I2C LCD command path.
//   cmd_valid : command byte on cmd_data is valid (master drives)
//   cmd_data  : LCD command byte (master drives)
//   cmd_ready : sink accepts cmd_data this cycle (slave drives)
interface joystick_cursor_nav_if;
  import joystick_cursor_nav_pkg::*;

  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_ready;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/joystick_cursor_nav_lockout_timer.sv
// nav_lockout_timer: post-move lockout down-counter.
//   clk_1MHz : clock
//   rst_n    : async active-low reset
//   load     : start a lockout window (loads LOCKOUT_CYCLES-1)
//   busy_c   : counter non-zero, new moves must be ignored
// LOCKOUT_CYCLES=1 loads zero, so there is effectively no lockout.
module nav_lockout_timer #(
  parameter int unsigned LOCKOUT_CYCLES = 200000
) (
  input  logic clk_1MHz,
  input  logic rst_n,
  input  logic load,
  output logic busy_c
);

  localparam int unsigned CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCKOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load on accept, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_c = (cnt_q != '0);

endmodule

// File: rtl/joystick_cursor_nav.sv
// joystick_cursor_nav: turns joystick direction pulses into a cursor position on
// a character LCD and emits a "set DDRAM address" command for every change.
//   clk_1MHz, rst_n          : clock, async active-low reset
//   joy_up/down/left/right   : one-cycle direction pulses (priority up>down>left>right)
//   cmd_if (master)          : cmd_valid/cmd_data out, cmd_ready in
//   cur_row, cur_col         : current cursor position
//   move_evt                 : one-cycle pulse when the position changed
module joystick_cursor_nav
  import joystick_cursor_nav_pkg::*;
#(
  parameter int unsigned      COLS           = LCD_COLS,
  parameter int unsigned      ROWS           = LCD_ROWS,
  parameter int unsigned      WRAP           = 1,
  parameter int unsigned      LOCKOUT_CYCLES = 200000,
  parameter logic [CMD_W-1:0] ROW1_BASE      = LCD_ROW1_BASE
) (
  input  logic                 clk_1MHz,
  input  logic                 rst_n,
  input  logic                 joy_up,
  input  logic                 joy_down,
  input  logic                 joy_left,
  input  logic                 joy_right,
  joystick_cursor_nav_if.master cmd_if,
  output logic                 cur_row,
  output logic [COL_W-1:0]     cur_col,
  output logic                 move_evt
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic             ROW_MAX = 1'(ROWS - 1);
  localparam logic             WRAP_EN = (WRAP != 0);

  cmd_state_e       state_q, state_d;
  logic             row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             move_evt_q, move_evt_d;
  logic             dirty_q, dirty_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0] cmd_data_q, cmd_data_d;

  logic             busy_c;
  logic             any_pulse_c;
  logic             accept_c;
  logic             moved_c;
  logic             nxt_row_c;
  logic [COL_W-1:0] nxt_col_c;
  cursor_pos_t      pos_c;

  nav_lockout_timer #(
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_lockout (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .load     (accept_c),
    .busy_c   (busy_c)
  );

  assign any_pulse_c = joy_up | joy_down | joy_left | joy_right;
  assign accept_c    = any_pulse_c & ~busy_c;

  // Candidate position for the highest-priority pulse; edges wrap or saturate.
  always_comb begin
    nxt_row_c = row_q;
    nxt_col_c = col_q;
    if (joy_up) begin
      if (row_q == 1'b0) nxt_row_c = WRAP_EN ? ROW_MAX : row_q;
      else               nxt_row_c = row_q - 1'b1;
    end else if (joy_down) begin
      if (row_q == ROW_MAX) nxt_row_c = WRAP_EN ? 1'b0 : row_q;
      else                  nxt_row_c = row_q + 1'b1;
    end else if (joy_left) begin
      if (col_q == '0) nxt_col_c = WRAP_EN ? COL_MAX : col_q;
      else             nxt_col_c = col_q - COL_W'(1);
    end else if (joy_right) begin
      if (col_q == COL_MAX) nxt_col_c = WRAP_EN ? '0 : col_q;
      else                  nxt_col_c = col_q + COL_W'(1);
    end
  end

  // A blocked move still starts a lockout but changes nothing else.
  assign moved_c = accept_c & ({nxt_row_c, nxt_col_c} != {row_q, col_q});

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    move_evt_d = 1'b0;
    if (accept_c) begin
      row_d      = nxt_row_c;
      col_d      = nxt_col_c;
      move_evt_d = moved_c;
    end
  end

  assign pos_c = '{row: row_q, col: col_q};

  // Command FSM: state register.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dirty_q)          state_d = ST_SEND;
      ST_SEND: if (cmd_if.cmd_ready) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Command FSM: outputs. A move in the same cycle as a latch or handshake
  // keeps dirty set so the newest position is always sent afterwards.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    dirty_d     = dirty_q;
    case (state_q)
      ST_IDLE: begin
        if (dirty_q) begin
          cmd_valid_d = 1'b1;
          cmd_data_d  = ddram_cmd(pos_c, ROW1_BASE);
          dirty_d     = 1'b0;
        end
      end
      ST_SEND: begin
        if (cmd_if.cmd_ready) cmd_valid_d = 1'b0;
      end
      default: begin
        cmd_valid_d = 1'b0;
      end
    endcase
    if (moved_c) dirty_d = 1'b1;
  end

  // Position, event and command registers.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= 1'b0;
      col_q       <= '0;
      move_evt_q  <= 1'b0;
      dirty_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= LCD_CMD_SET_DDRAM;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      move_evt_q  <= move_evt_d;
      dirty_q     <= dirty_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  assign cur_row          = row_q;
  assign cur_col          = col_q;
  assign move_evt         = move_evt_q;
  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd_data  = cmd_data_q;

endmodule
